serial_subtractor: RTL and testbench

Bit-serial two's-complement subtractor. It computes d = a - b - bin, one bit per clock, LSB first, using a single 1-bit full-subtractor cell and a registered borrow. It is the subtract-direction counterpart of the team's bit-serial adder and feeds the same ALU datapath. A start/ready/done handshake frames each operation.

---
 rtl/serial_subtractor.sv | 129 ++++++++++++
 tb/tb_serial_subtractor.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor, d = a - b - bin.
// One full-subtractor cell processes one bit per clock, LSB first, with the
// borrow held in a register between steps.
//
// State table:
//   IDLE | waiting for start; ready=1
//   RUN  | shifting operands through the subtractor cell, WIDTH steps
//   DONE | result just published; done=1, ready=1 (back-to-back start allowed)
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           request an operation (accepted only while ready=1)
//   a, b, bin       minuend, subtrahend, borrow-in (sampled on accept edge)
//   ready, busy     handshake status
//   done            one-cycle pulse when d/BF/OF update
//   d, BF, OF       difference, borrow flag, signed overflow flag
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             BF,
    output logic             OF
);

    // Counter must reach WIDTH without wrapping, including WIDTH=32.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             a_msb;
    logic             b_msb;

    logic             diff;
    logic             borrow_next;
    logic             accept;
    logic             last_step;
    logic [WIDTH-1:0] res_next;

    always_comb begin
        diff        = sa[0] ^ sb[0] ^ borrow;
        borrow_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow);
        accept      = start & ready;
        last_step   = (cnt == CW'(WIDTH - 1));
        res_next    = {diff, res[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ready  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
            d      <= '0;
            BF     <= 1'b0;
            OF     <= 1'b0;
            sa     <= '0;
            sb     <= '0;
            res    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
        end else if (accept) begin
            // Reachable from IDLE and DONE alike; ready is only high there.
            state  <= RUN;
            ready  <= 1'b0;
            busy   <= 1'b1;
            done   <= 1'b0;
            sa     <= a;
            sb     <= b;
            borrow <= bin;
            res    <= '0;
            cnt    <= '0;
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
        end else begin
            case (state)
                IDLE: begin
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                RUN: begin
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    res    <= res_next;
                    borrow <= borrow_next;
                    cnt    <= cnt + CW'(1);
                    if (last_step) begin
                        d     <= res_next;
                        BF    <= borrow_next;
                        // diff on the last step is the result sign bit
                        OF    <= (a_msb != b_msb) & (diff != a_msb);
                        state <= DONE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized bench for serial_subtractor at WIDTH=8 and WIDTH=2.
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic       bin;
    logic       ready, busy, done;
    logic [7:0] d;
    logic       BF, OF;

    logic       start2;
    logic [1:0] a2, b2;
    logic       bin2;
    logic       ready2, busy2, done2;
    logic [1:0] d2;
    logic       BF2, OF2;

    int n_cmp;
    int n_bad;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .ready(ready), .busy(busy), .done(done), .d(d), .BF(BF), .OF(OF)
    );

    serial_subtractor #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .bin(bin2),
        .ready(ready2), .busy(busy2), .done(done2), .d(d2), .BF(BF2), .OF(OF2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus driver: issues one op and waits for done (bounded); lat=-1 on timeout.
    task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                       output logic [7:0] od, output logic obf, output logic oof,
                       output int lat, output int bcnt);
        start = 1'b1; a = ia; b = ib; bin = ibin;
        tick();
        start = 1'b0;
        lat  = -1;
        bcnt = 0;
        for (int i = 1; i <= 20; i++) begin
            if (busy) bcnt++;
            tick();
            if (done) begin
                lat = i;
                break;
            end
        end
        od = d; obf = BF; oof = OF;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({ready, busy, done, d, BF, OF} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset8: got rdy=%b busy=%b done=%b d=%h BF=%b OF=%b, want 1 0 0 00 0 0",
                     ready, busy, done, d, BF, OF);
        end
        n_cmp++;
        if ({ready2, busy2, done2, d2, BF2, OF2} !== {1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset2: got rdy=%b busy=%b done=%b d=%h BF=%b OF=%b, want 1 0 0 0 0 0",
                     ready2, busy2, done2, d2, BF2, OF2);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] rd; logic rbf, rof; int lat, bc;
        op8(8'h35, 8'h12, 1'b0, rd, rbf, rof, lat, bc);
        n_cmp++;
        if (lat !== 8) begin
            n_bad++; $display("FAIL basic_latency: got %0d, want 8", lat);
        end
        n_cmp++;
        if (bc !== 8) begin
            n_bad++; $display("FAIL basic_busy_cycles: got %0d, want 8", bc);
        end
        n_cmp++;
        if ({rd, rbf, rof} !== {8'h23, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL basic_35_12: got d=%h BF=%b OF=%b, want 23 0 0", rd, rbf, rof);
        end
        tick();
        n_cmp++;
        if ({done, ready, busy} !== 3'b010) begin
            n_bad++; $display("FAIL done_pulse_width: got done=%b rdy=%b busy=%b, want 0 1 0", done, ready, busy);
        end
    endtask

    task automatic test_borrow();
        logic [7:0] rd; logic rbf, rof; int lat, bc;
        op8(8'h10, 8'h20, 1'b0, rd, rbf, rof, lat, bc);
        n_cmp++;
        if ({rd, rbf, rof} !== {8'hF0, 1'b1, 1'b0} || lat !== 8) begin
            n_bad++; $display("FAIL borrow_10_20: got d=%h BF=%b OF=%b lat=%0d, want F0 1 0 8", rd, rbf, rof, lat);
        end
        tick();
        op8(8'h00, 8'h00, 1'b1, rd, rbf, rof, lat, bc);
        n_cmp++;
        if ({rd, rbf, rof} !== {8'hFF, 1'b1, 1'b0} || lat !== 8) begin
            n_bad++; $display("FAIL borrow_bin: got d=%h BF=%b OF=%b lat=%0d, want FF 1 0 8", rd, rbf, rof, lat);
        end
        tick();
    endtask

    task automatic test_overflow();
        logic [7:0] rd; logic rbf, rof; int lat, bc;
        op8(8'h80, 8'h01, 1'b0, rd, rbf, rof, lat, bc);
        n_cmp++;
        if ({rd, rbf, rof} !== {8'h7F, 1'b0, 1'b1} || lat !== 8) begin
            n_bad++; $display("FAIL ovf_80_01: got d=%h BF=%b OF=%b lat=%0d, want 7F 0 1 8", rd, rbf, rof, lat);
        end
        tick();
        op8(8'h7F, 8'hFF, 1'b0, rd, rbf, rof, lat, bc);
        n_cmp++;
        if ({rd, rbf, rof} !== {8'h80, 1'b1, 1'b1} || lat !== 8) begin
            n_bad++; $display("FAIL ovf_7F_FF: got d=%h BF=%b OF=%b lat=%0d, want 80 1 1 8", rd, rbf, rof, lat);
        end
        tick();
    endtask

    task automatic test_idle_hold();
        // Last result was 7F-FF = 80/BF=1/OF=1; inputs wiggle, start stays low.
        for (int i = 0; i < 6; i++) begin
            a = 8'(i * 37); b = 8'(i * 11); bin = i[0];
            tick();
        end
        n_cmp++;
        if ({d, BF, OF, done, ready, busy} !== {8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL idle_hold: got d=%h BF=%b OF=%b done=%b rdy=%b busy=%b, want 80 1 1 0 1 0",
                              d, BF, OF, done, ready, busy);
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        start = 1'b1; a = 8'h80; b = 8'h01; bin = 1'b0;
        tick();
        start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            if (i == 3) begin
                start = 1'b1; a = 8'h11; b = 8'h22; bin = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
        n_cmp++;
        if ({d, BF, OF} !== {8'h7F, 1'b0, 1'b1} || lat !== 8) begin
            n_bad++; $display("FAIL ignore_start: got d=%h BF=%b OF=%b lat=%0d, want 7F 0 1 8", d, BF, OF, lat);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat;
        start = 1'b1; a = 8'h35; b = 8'h12; bin = 1'b0;
        tick();
        a = 8'hAA; b = 8'h55;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (done) begin
                lat = i;
                break;
            end
        end
        n_cmp++;
        if ({d, BF, OF} !== {8'h23, 1'b0, 1'b0} || lat !== 8) begin
            n_bad++; $display("FAIL b2b_first: got d=%h BF=%b OF=%b lat=%0d, want 23 0 0 8", d, BF, OF, lat);
        end
        tick();
        start = 1'b0;
        n_cmp++;
        if ({busy, ready, done} !== 3'b100) begin
            n_bad++; $display("FAIL b2b_no_gap: got busy=%b rdy=%b done=%b, want 1 0 0", busy, ready, done);
        end
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (done) begin
                lat = i;
                break;
            end
        end
        n_cmp++;
        if ({d, BF, OF} !== {8'h55, 1'b0, 1'b1} || lat !== 8) begin
            n_bad++; $display("FAIL b2b_second: got d=%h BF=%b OF=%b lat=%0d, want 55 0 1 8", d, BF, OF, lat);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] rd; logic rbf, rof; int lat, bc, ndone;
        start = 1'b1; a = 8'hF0; b = 8'h0F; bin = 1'b0;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({d, BF, OF, ready, busy, done} !== {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL rst_mid_run: got d=%h BF=%b OF=%b rdy=%b busy=%b done=%b, want 00 0 0 1 0 0",
                              d, BF, OF, ready, busy, done);
        end
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) ndone++;
            tick();
        end
        n_cmp++;
        if (ndone !== 0) begin
            n_bad++; $display("FAIL rst_no_done: got %0d done pulses, want 0", ndone);
        end
        op8(8'hF0, 8'h0F, 1'b0, rd, rbf, rof, lat, bc);
        n_cmp++;
        if ({rd, rbf, rof} !== {8'hE1, 1'b0, 1'b0} || lat !== 8) begin
            n_bad++; $display("FAIL rst_then_op: got d=%h BF=%b OF=%b lat=%0d, want E1 0 0 8", rd, rbf, rof, lat);
        end
        tick();
    endtask

    task automatic test_random8();
        logic [7:0] ra, rb, rd, ed; logic rbin, rbf, rof, ebf, eof; logic [8:0] full;
        int lat, bc;
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
            full = {1'b0, ra} - {1'b0, rb} - {8'h00, rbin};
            ed   = full[7:0];
            ebf  = full[8];
            eof  = (ra[7] != rb[7]) && (ed[7] != ra[7]);
            op8(ra, rb, rbin, rd, rbf, rof, lat, bc);
            n_cmp++;
            if ({rd, rbf, rof} !== {ed, ebf, eof} || lat !== 8) begin
                n_bad++;
                $display("FAIL rand8 %h-%h-%b: got d=%h BF=%b OF=%b lat=%0d, want %h %b %b 8",
                         ra, rb, rbin, rd, rbf, rof, lat, ed, ebf, eof);
            end
        end
        tick();
    endtask

    task automatic test_width2();
        logic [1:0] ra, rb, ed; logic rbin, ebf, eof; logic [2:0] full;
        int lat;
        for (int n = 0; n < 32; n++) begin
            ra = 2'(n >> 3); rb = 2'(n >> 1); rbin = 1'(n);
            full = {1'b0, ra} - {1'b0, rb} - {2'b00, rbin};
            ed   = full[1:0];
            ebf  = full[2];
            eof  = (ra[1] != rb[1]) && (ed[1] != ra[1]);
            start2 = 1'b1; a2 = ra; b2 = rb; bin2 = rbin;
            tick();
            start2 = 1'b0;
            lat = -1;
            for (int i = 1; i <= 10; i++) begin
                tick();
                if (done2) begin
                    lat = i;
                    break;
                end
            end
            n_cmp++;
            if ({d2, BF2, OF2} !== {ed, ebf, eof} || lat !== 2) begin
                n_bad++;
                $display("FAIL w2 %h-%h-%b: got d=%h BF=%b OF=%b lat=%0d, want %h %b %b 2",
                         ra, rb, rbin, d2, BF2, OF2, lat, ed, ebf, eof);
            end
            tick();
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; bin2 = 1'b0;
        test_reset();
        test_basic();
        test_borrow();
        test_overflow();
        test_idle_hold();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_random8();
        test_width2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
